dkong_dl_router: RTL

//  Sits between hps_io's ioctl download stream and the ROM dprams, dkong_top DL_* port and mod/DIP consumers.

---
 rtl/dkong_dl_router_if.sv | 24 ++
 rtl/dkong_dl_router.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dkong_dl_router_if.sv
// dkong_dl_router_if
//   Carries the hps_io ioctl download stream into the ROM/mod/DIP router.
//   master: the download source (hps_io); drives every signal.
//   slave : the router; samples every signal.
//   ioctl_download  download active
//   ioctl_wr        byte strobe, one clk_sys cycle per byte
//   ioctl_index     0=ROM image, 1=mod byte, 254=DIP bytes
//   ioctl_addr      25-bit byte address
//   ioctl_dout      byte data
interface dkong_dl_router_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
    );
endinterface

// File: rtl/dkong_dl_router.sv
// dkong_dl_router
//   Routes the ioctl download stream to the ROM dprams and dkong_top DL_* port.
//   Index-0 bytes become registered per-region write strobes with region-relative
//   addresses (latency 1, width 1). Index-1 latches the one-hot game select,
//   index-254 latches DIP byte 0. Tracks byte count and 16-bit additive checksum
//   of the ROM image and gates core run via rom_ready.
// Ports:
//   clk_sys, reset            clock, synchronous active-high power-on reset
//   ioctl (slave)             download stream
//   cpu_wr/cpu_addr           main CPU ROM write (32 KiB at CPU_BASE)
//   snd_wr/snd_addr           sound CPU ROM write (4 KiB at SND_BASE)
//   wav_wr/wav_addr           wave ROM write (64 KiB at WAV_BASE)
//   dl_wr/dl_addr             dkong_top DL_* write (index 0, addr < 64 KiB)
//   wr_data                   data shared by all strobes
//   mod_*                     one-hot game select
//   dip_sw0                   DIP byte 0
//   rom_ready/rom_error       image valid / last image too short
//   rom_sum                   sum of index-0 bytes mod 2^16
module dkong_dl_router #(
    parameter logic [23:0] CPU_BASE  = 24'h000000,
    parameter logic [23:0] SND_BASE  = 24'h00E000,
    parameter logic [23:0] WAV_BASE  = 24'h010000,
    parameter logic [23:0] MIN_BYTES = 24'h020000
) (
    input  logic             clk_sys,
    input  logic             reset,
    dkong_dl_router_if.slave ioctl,
    output logic             cpu_wr,
    output logic [14:0]      cpu_addr,
    output logic             snd_wr,
    output logic [11:0]      snd_addr,
    output logic             wav_wr,
    output logic [15:0]      wav_addr,
    output logic             dl_wr,
    output logic [15:0]      dl_addr,
    output logic [7:0]       wr_data,
    output logic             mod_dk,
    output logic             mod_dkjr,
    output logic             mod_dk3,
    output logic             mod_radarscope,
    output logic             mod_pestplace,
    output logic [7:0]       dip_sw0,
    output logic             rom_ready,
    output logic             rom_error,
    output logic [15:0]      rom_sum
);

    localparam logic [24:0] CPU_LO = {1'b0, CPU_BASE};
    localparam logic [24:0] CPU_HI = CPU_LO + 25'd32768;
    localparam logic [24:0] SND_LO = {1'b0, SND_BASE};
    localparam logic [24:0] SND_HI = SND_LO + 25'd4096;
    localparam logic [24:0] WAV_LO = {1'b0, WAV_BASE};
    localparam logic [24:0] WAV_HI = WAV_LO + 25'd65536;
    localparam logic [24:0] DL_HI  = 25'h0010000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINISH,
        ST_READY,
        ST_FAIL
    } state_t;

    state_t      state;
    logic        dl_q;
    logic [23:0] count;
    logic        rise, fall, idx_rom, accept;
    logic        in_cpu, in_snd, in_wav, in_dl;
    logic [24:0] addr;

    always_comb begin
        addr    = ioctl.ioctl_addr;
        rise    = ioctl.ioctl_download & ~dl_q;
        fall    = ~ioctl.ioctl_download & dl_q;
        idx_rom = (ioctl.ioctl_index == 8'd0);
        accept  = (state == ST_LOAD) && ioctl.ioctl_wr && idx_rom;
        in_cpu  = (addr >= CPU_LO) && (addr < CPU_HI);
        in_snd  = (addr >= SND_LO) && (addr < SND_HI);
        in_wav  = (addr >= WAV_LO) && (addr < WAV_HI);
        in_dl   = (addr < DL_HI);
    end

    // Edge-detect register follows ioctl_download even through reset, so a
    // download still high after a mid-load reset is not seen as a new start.
    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl.ioctl_download;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= ST_IDLE;
            cpu_wr         <= 1'b0;
            snd_wr         <= 1'b0;
            wav_wr         <= 1'b0;
            dl_wr          <= 1'b0;
            cpu_addr       <= '0;
            snd_addr       <= '0;
            wav_addr       <= '0;
            dl_addr        <= '0;
            wr_data        <= '0;
            count          <= '0;
            rom_sum        <= '0;
            rom_ready      <= 1'b0;
            rom_error      <= 1'b0;
            mod_dk         <= 1'b1;
            mod_dkjr       <= 1'b0;
            mod_dk3        <= 1'b0;
            mod_radarscope <= 1'b0;
            mod_pestplace  <= 1'b0;
            dip_sw0        <= '0;
        end else begin
            cpu_wr <= accept && in_cpu;
            snd_wr <= accept && in_snd;
            wav_wr <= accept && in_wav;
            dl_wr  <= accept && in_dl;

            // accept implies ST_LOAD, so this never races the clear below.
            if (accept) begin
                cpu_addr <= 15'(addr - CPU_LO);
                snd_addr <= 12'(addr - SND_LO);
                wav_addr <= 16'(addr - WAV_LO);
                dl_addr  <= addr[15:0];
                wr_data  <= ioctl.ioctl_dout;
                rom_sum  <= rom_sum + {8'd0, ioctl.ioctl_dout};
                if (count != '1) begin
                    count <= count + 24'd1;
                end
            end

            case (state)
                ST_IDLE, ST_READY, ST_FAIL: begin
                    if (rise && idx_rom) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        rom_sum   <= '0;
                        rom_ready <= 1'b0;
                        rom_error <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (fall) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (count >= MIN_BYTES) begin
                        state     <= ST_READY;
                        rom_ready <= 1'b1;
                    end else begin
                        state     <= ST_FAIL;
                        rom_error <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd1)) begin
                mod_dk         <= (ioctl.ioctl_dout == 8'd0);
                mod_dkjr       <= (ioctl.ioctl_dout == 8'd1);
                mod_dk3        <= (ioctl.ioctl_dout == 8'd2);
                mod_radarscope <= (ioctl.ioctl_dout == 8'd3);
                mod_pestplace  <= (ioctl.ioctl_dout == 8'd4);
            end

            // Only DIP byte 0 has a consumer; addresses 1..7 are accepted and dropped.
            if (ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd254) && (addr == 25'd0)) begin
                dip_sw0 <= ioctl.ioctl_dout;
            end
        end
    end

endmodule
